// File: rtl/config_pkg.sv
// Shared types and constants for the config write arbiter.
// Holds the config write payload, the issue-path FSM encoding and the
// saturating counter helper used by the optional statistics
// (build macro CONFIG_ARB_STATS_EN).
package config_pkg;

    localparam int CONFIG_ADDR_BITS = 16;
    localparam int CONFIG_DATA_BITS = 32;
    localparam int GAP_CNT_BITS     = 8;
    localparam int STAT_BITS        = 32;

    typedef struct packed {
        logic [CONFIG_ADDR_BITS-1:0] addr;
        logic [CONFIG_DATA_BITS-1:0] data;
    } config_write_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_GAP   = 2'd2
    } arb_state_t;

    // Increment that sticks at all-ones instead of wrapping.
    function automatic logic [STAT_BITS-1:0] sat_inc(input logic [STAT_BITS-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/config_write_arbiter_rr.sv
// Round-robin arbiter: combinational one-hot grant searched from the
// pointer upward with wrap, pointer moving past the winner on advance.
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [N-1:0]                    valid,
    input  logic                            advance,
    output logic [N-1:0]                    grant,
    output logic [$clog2(N>1?N:2)-1:0]      pointer
);

    localparam int PW = $clog2(N > 1 ? N : 2);

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic          found;
    int            idx;

    // First valid requester at or after the pointer, wrapping N-1 -> 0.
    always_comb begin
        grant = '0;
        found = 1'b0;
        idx   = 0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr_q) + k) % N;
            for (int i = 0; i < N; i++) begin
                if (!found && (i == idx) && valid[i]) begin
                    grant[i] = 1'b1;
                    found    = 1'b1;
                end
            end
        end
    end

    // Pointer moves to the slot just after the winner, only on a transfer.
    always_comb begin
        ptr_d = ptr_q;
        if (advance) begin
            for (int k = 0; k < N; k++) begin
                if (grant[k]) begin
                    ptr_d = (k == N - 1) ? '0 : PW'(k + 1);
                end
            end
        end
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign pointer = ptr_q;

endmodule

// File: rtl/config_write_arbiter.sv
// Config write arbiter: merges N_REQ ready/valid write ports onto a single
// config bus with one-cycle valid pulses and an optional enforced idle gap
// between pulses. Build macro CONFIG_ARB_STATS_EN adds per-requester
// saturating accepted-write counters on grant_count.
module config_write_arbiter
    import config_pkg::*;
#(
    parameter int N_REQ      = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic                               clk,
    input  logic                               rst_n,
    input  logic [N_REQ-1:0]                   req_valid,
    output logic [N_REQ-1:0]                   req_ready,
    input  logic [N_REQ*CONFIG_ADDR_BITS-1:0]  req_addr,
    input  logic [N_REQ*CONFIG_DATA_BITS-1:0]  req_data,
    output logic                               conf_valid,
    output logic [CONFIG_ADDR_BITS-1:0]        conf_addr,
    output logic [CONFIG_DATA_BITS-1:0]        conf_data
`ifdef CONFIG_ARB_STATS_EN
    ,
    output logic [N_REQ*STAT_BITS-1:0]         grant_count
`endif
);

    localparam int                PW       = $clog2(N_REQ > 1 ? N_REQ : 2);
    localparam logic [GAP_CNT_BITS-1:0] GAP_LOAD = GAP_CNT_BITS'(GAP_CYCLES);

    config_write_t                req_wr [N_REQ];
    config_write_t                sel_wr;
    logic [N_REQ-1:0]             grant;
    logic [PW-1:0]                rr_pointer;
    logic                         accept_en;
    logic                         transfer;

    arb_state_t                   state_q, state_d;
    logic [GAP_CNT_BITS-1:0]      gap_cnt_q, gap_cnt_d;
    logic                         conf_valid_q, conf_valid_d;
    logic [CONFIG_ADDR_BITS-1:0]  conf_addr_q, conf_addr_d;
    logic [CONFIG_DATA_BITS-1:0]  conf_data_q, conf_data_d;

    for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
        assign req_wr[i].addr = req_addr[i*CONFIG_ADDR_BITS +: CONFIG_ADDR_BITS];
        assign req_wr[i].data = req_data[i*CONFIG_DATA_BITS +: CONFIG_DATA_BITS];
    end

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .valid   (req_valid),
        .advance (transfer),
        .grant   (grant),
        .pointer (rr_pointer)
    );

    // Acceptance window: always in IDLE, back-to-back in ISSUE only with no
    // gap, and on the last gap cycle so the next pulse lands right after it.
    always_comb begin
        accept_en = 1'b0;
        case (state_q)
            ST_IDLE:  accept_en = 1'b1;
            ST_ISSUE: accept_en = (GAP_CYCLES == 0);
            ST_GAP:   accept_en = (gap_cnt_q == 8'd1);
            default:  accept_en = 1'b0;
        endcase
    end

    // Ready goes only to the granted requester, and never while in reset.
    assign req_ready = grant & {N_REQ{accept_en & rst_n}};
    assign transfer  = |(req_valid & req_ready);

    // Payload of the granted requester (grant is one-hot or zero).
    always_comb begin
        sel_wr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (grant[i]) begin
                sel_wr = req_wr[i];
            end
        end
    end

    // Issue-path FSM next state and gap counter.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (transfer) begin
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (GAP_CYCLES == 0) begin
                    state_d = transfer ? ST_ISSUE : ST_IDLE;
                end else begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_LOAD;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q > 8'd1) begin
                    gap_cnt_d = gap_cnt_q - 8'd1;
                end else begin
                    gap_cnt_d = '0;
                    state_d   = transfer ? ST_ISSUE : ST_IDLE;
                end
            end
            default: begin
                state_d   = ST_IDLE;
                gap_cnt_d = '0;
            end
        endcase
    end

    // Output bus: one-cycle pulse per accepted write, payload held otherwise.
    always_comb begin
        conf_valid_d = transfer;
        conf_addr_d  = transfer ? sel_wr.addr : conf_addr_q;
        conf_data_d  = transfer ? sel_wr.data : conf_data_q;
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            gap_cnt_q    <= '0;
            conf_valid_q <= 1'b0;
            conf_addr_q  <= '0;
            conf_data_q  <= '0;
        end else begin
            state_q      <= state_d;
            gap_cnt_q    <= gap_cnt_d;
            conf_valid_q <= conf_valid_d;
            conf_addr_q  <= conf_addr_d;
            conf_data_q  <= conf_data_d;
        end
    end

    // A pulse registered just before reset is suppressed while reset is held.
    assign conf_valid = conf_valid_q & rst_n;
    assign conf_addr  = conf_addr_q;
    assign conf_data  = conf_data_q;

    ptr_in_range: assert property (@(posedge clk) int'(rr_pointer) < N_REQ);
    ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));

`ifdef CONFIG_ARB_STATS_EN
    logic [STAT_BITS-1:0] grant_count_q [N_REQ];
    logic [STAT_BITS-1:0] grant_count_d [N_REQ];

    // Per-requester accepted-write counters, saturating at all-ones.
    always_comb begin
        for (int i = 0; i < N_REQ; i++) begin
            grant_count_d[i] = (req_valid[i] && req_ready[i]) ?
                               sat_inc(grant_count_q[i]) : grant_count_q[i];
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_count_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_REQ; i++) begin
                grant_count_q[i] <= grant_count_d[i];
            end
        end
    end

    for (genvar i = 0; i < N_REQ; i++) begin : g_stats
        assign grant_count[i*STAT_BITS +: STAT_BITS] = grant_count_q[i];
    end
`endif

endmodule

// File: tb/tb_config_write_arbiter.sv
// Directed bench for config_write_arbiter: three instances (N=2/gap 0,
// N=1/gap 3, N=4/gap 2) sharing clock and reset, exercised in turn.
module tb_config_write_arbiter;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   total = 0;
    int   bad   = 0;

    // Instance A: N_REQ=2, GAP_CYCLES=0
    logic [1:0]   a_valid, a_ready;
    logic [31:0]  a_addr;
    logic [63:0]  a_data;
    logic         a_cv;
    logic [15:0]  a_ca;
    logic [31:0]  a_cd;
    // Instance B: N_REQ=1, GAP_CYCLES=3
    logic [0:0]   b_valid, b_ready;
    logic [15:0]  b_addr;
    logic [31:0]  b_data;
    logic         b_cv;
    logic [15:0]  b_ca;
    logic [31:0]  b_cd;
    // Instance C: N_REQ=4, GAP_CYCLES=2
    logic [3:0]   c_valid, c_ready;
    logic [63:0]  c_addr;
    logic [127:0] c_data;
    logic         c_cv;
    logic [15:0]  c_ca;
    logic [31:0]  c_cd;
`ifdef CONFIG_ARB_STATS_EN
    logic [63:0]  a_gc;
    logic [31:0]  b_gc;
    logic [127:0] c_gc;
`endif

    config_write_arbiter #(.N_REQ(2), .GAP_CYCLES(0)) u_a (
        .clk(clk), .rst_n(rst_n), .req_valid(a_valid), .req_ready(a_ready),
        .req_addr(a_addr), .req_data(a_data), .conf_valid(a_cv),
        .conf_addr(a_ca), .conf_data(a_cd)
`ifdef CONFIG_ARB_STATS_EN
        , .grant_count(a_gc)
`endif
    );

    config_write_arbiter #(.N_REQ(1), .GAP_CYCLES(3)) u_b (
        .clk(clk), .rst_n(rst_n), .req_valid(b_valid), .req_ready(b_ready),
        .req_addr(b_addr), .req_data(b_data), .conf_valid(b_cv),
        .conf_addr(b_ca), .conf_data(b_cd)
`ifdef CONFIG_ARB_STATS_EN
        , .grant_count(b_gc)
`endif
    );

    config_write_arbiter #(.N_REQ(4), .GAP_CYCLES(2)) u_c (
        .clk(clk), .rst_n(rst_n), .req_valid(c_valid), .req_ready(c_ready),
        .req_addr(c_addr), .req_data(c_data), .conf_valid(c_cv),
        .conf_addr(c_ca), .conf_data(c_cd)
`ifdef CONFIG_ARB_STATS_EN
        , .grant_count(c_gc)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        int pcyc [4];
        logic [15:0] paddr [4];
        int gseq [3];
        int npulse, nq, ng;
        logic xfer;

        a_valid = '0; a_addr = '0; a_data = '0;
        b_valid = '0; b_addr = '0; b_data = '0;
        c_valid = '0; c_data = '0;
        c_addr  = {16'h0033, 16'h0032, 16'h0031, 16'h0030};

        // Reset: ready held low even with valids asserted, outputs cleared
        rst_n = 1'b0;
        a_valid = 2'b11; b_valid = 1'b1; c_valid = 4'hF;
        tick(); tick();
        chk("rst_ready_a", 64'(a_ready), 64'd0);
        chk("rst_ready_b", 64'(b_ready), 64'd0);
        chk("rst_ready_c", 64'(c_ready), 64'd0);
        chk("rst_cv_a", 64'(a_cv), 64'd0);
        chk("rst_ca_a", 64'(a_ca), 64'd0);
        chk("rst_cd_a", 64'(a_cd), 64'd0);
`ifdef CONFIG_ARB_STATS_EN
        chk("rst_gc_a", a_gc, 64'd0);
`endif
        a_valid = '0; b_valid = '0; c_valid = '0;
        rst_n = 1'b1;
        tick();

        // Single write from req0: pulse one cycle later, payload held after
        a_addr[15:0] = 16'h0010; a_data[31:0] = 32'h0000_000A;
        a_valid = 2'b01;
        #1 chk("w1_ready", 64'(a_ready), 64'h1);
        tick();
        a_valid = '0;
        chk("w1_cv", 64'(a_cv), 64'd1);
        chk("w1_addr", 64'(a_ca), 64'h10);
        chk("w1_data", 64'(a_cd), 64'hA);
        tick();
        chk("w1_cv_off", 64'(a_cv), 64'd0);
        chk("w1_addr_hold", 64'(a_ca), 64'h10);
        chk("w1_data_hold", 64'(a_cd), 64'hA);

        // Both requesters continuously valid from pointer 0: 0,1,0,1
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        a_addr = {16'h0101, 16'h0100};
        a_data = {32'h1000_0001, 32'h1000_0000};
        a_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            #1 chk("alt_ready", 64'(a_ready), (k % 2) ? 64'h2 : 64'h1);
            tick();
            chk("alt_cv", 64'(a_cv), 64'd1);
            chk("alt_addr", 64'(a_ca), 64'h100 + 64'(k % 2));
        end
        a_valid = '0;
        tick();
        chk("alt_cv_end", 64'(a_cv), 64'd0);

        // Gap of 3: four queued writes pulse at offsets 1,5,9,13
        b_addr = 16'h0020; b_data = 32'd0; b_valid = 1'b1;
        nq = 0; npulse = 0;
        for (int k = 0; k < 16; k++) begin
            #1 xfer = b_valid[0] & b_ready[0];
            tick();
            if (b_cv) begin
                if (npulse < 4) begin
                    pcyc[npulse]  = k + 1;
                    paddr[npulse] = b_ca;
                end
                npulse++;
            end
            if (xfer) begin
                nq++;
                if (nq == 4) b_valid = 1'b0;
                else begin
                    b_addr = 16'h0020 + 16'(nq);
                    b_data = 32'(nq);
                end
            end
        end
        chk("gap_pulses", 64'(npulse), 64'd4);
        for (int i = 0; i < 4; i++) begin
            chk("gap_cycle", 64'(pcyc[i]), 64'(1 + 4 * i));
            chk("gap_addr", 64'(paddr[i]), 64'h20 + 64'(i));
        end

        // N=4: pointer moved to 2 by a req1 write, then req3/req1 contend
        c_valid = 4'b0010;
        #1 chk("rr_setup_ready", 64'(c_ready), 64'h2);
        tick();
        c_valid = '0;
        repeat (4) tick();
        c_valid = 4'b1010;
        ng = 0;
        for (int k = 0; k < 20 && ng < 3; k++) begin
            #1;
            if (c_ready != 4'b0000) begin
                for (int i = 0; i < 4; i++) if (c_ready[i]) gseq[ng] = i;
                ng++;
            end
            tick();
        end
        c_valid = '0;
        chk("rr_count", 64'(ng), 64'd3);
        chk("rr_g0", 64'(gseq[0]), 64'd3);
        chk("rr_g1", 64'(gseq[1]), 64'd1);
        chk("rr_g2", 64'(gseq[2]), 64'd3);
        repeat (4) tick();

        // Reset one cycle after a transfer: pulse dropped, pointer back to 0
        c_valid = 4'b0100;
        #1 chk("mrst_ready", 64'(c_ready), 64'h4);
        tick();
        c_valid = '0;
        rst_n = 1'b0;
        #1 chk("mrst_cv_in_rst", 64'(c_cv), 64'd0);
        tick();
        rst_n = 1'b1;
        chk("mrst_cv_after", 64'(c_cv), 64'd0);
        chk("mrst_addr_clr", 64'(c_ca), 64'd0);
        c_valid = 4'b1111;
        #1 chk("mrst_ptr0", 64'(c_ready), 64'h1);
        tick();
        c_valid = '0;
        chk("mrst_cv_next", 64'(c_cv), 64'd1);
        chk("mrst_addr_next", 64'(c_ca), 64'h30);

`ifdef CONFIG_ARB_STATS_EN
        // Counters: 7 writes from req1, 2 from req0
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        a_valid = 2'b10;
        repeat (7) tick();
        a_valid = 2'b01;
        repeat (2) tick();
        a_valid = '0;
        tick();
        chk("stats_gc1", 64'(a_gc[63:32]), 64'd7);
        chk("stats_gc0", 64'(a_gc[31:0]), 64'd2);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
